// File: rtl/gray_enc_arbiter.sv
// Round-robin arbiter feeding one shared binary-to-Gray stage with a registered output slot.
// Define GRAY_ENC_ARBITER_PARITY_EN to add the out_par port (parity of the accepted binary word).
module gray_enc_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_gray,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready
`ifdef GRAY_ENC_ARBITER_PARITY_EN
    ,output logic           out_par
`endif
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    gray_q, gray_d;
    logic [SW-1:0]   src_q, src_d;
    logic [SW-1:0]   rr_q, rr_d;
    logic            can_take;
    logic            found;
    logic            take;
    logic [SW-1:0]   gnt_idx;
    logic [SW-1:0]   idx;
    logic [W-1:0]    word;

    // First asserted request at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = SW'((int'(rr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign can_take = (state_q == EMPTY) | (out_ready & out_valid);
    assign take     = can_take & found & ~rst;
    assign word     = req_data[int'(gnt_idx)*W +: W];

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (take) begin
            state_d = FULL;
            gray_d  = word ^ (word >> 1);
            src_d   = gnt_idx;
            rr_d    = SW'((int'(gnt_idx) + 1) % NREQ);
        end else if (out_valid && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            gray_q  <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_gray  = gray_q;
    assign out_src   = src_q;

`ifdef GRAY_ENC_ARBITER_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (take) begin
            par_d = ^word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_gray_enc_arbiter.sv
// Directed table-driven bench for gray_enc_arbiter (NREQ=4, W=8).
// Builds with or without GRAY_ENC_ARBITER_PARITY_EN.
module tb_gray_enc_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int SW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            out_valid;
    logic [W-1:0]    out_gray;
    logic [SW-1:0]   out_src;
    logic            out_ready;
`ifdef GRAY_ENC_ARBITER_PARITY_EN
    logic            out_par;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_enc_arbiter #(.NREQ(NREQ), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef GRAY_ENC_ARBITER_PARITY_EN
        ,.out_par  (out_par)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [7:0]  e_gray;
        logic [1:0]  e_src;
    } vec_t;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int i, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        req_data  = v.data;
        out_ready = v.ordy;
        #1;
        check("req_ready", i, 32'(req_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        check("out_valid", i, 32'(out_valid), 32'(v.e_valid));
        check("out_gray", i, 32'(out_gray), 32'(v.e_gray));
        check("out_src", i, 32'(out_src), 32'(v.e_src));
    endtask

    // d3=0x00 d2=0x0A d1=0xFF d0=0x80
    localparam logic [31:0] D = 32'h000A_FF80;

    vec_t vecs[22];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;

        //          rst   valid    data           ordy  ready    v     gray   src
        vecs[0]  = '{1'b1, 4'b0000, D,             1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 4'b1111, D,             1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 4'b0000, D,             1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[3]  = '{1'b0, 4'b0010, 32'h0000_5500, 1'b1, 4'b0010, 1'b1, 8'h7F, 2'd1};
        vecs[4]  = '{1'b0, 4'b0000, D,             1'b1, 4'b0000, 1'b0, 8'h7F, 2'd1};
        vecs[5]  = '{1'b1, 4'b0000, D,             1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[6]  = '{1'b0, 4'b1111, D,             1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0};
        vecs[7]  = '{1'b0, 4'b1111, D,             1'b1, 4'b0010, 1'b1, 8'h80, 2'd1};
        vecs[8]  = '{1'b0, 4'b1111, D,             1'b1, 4'b0100, 1'b1, 8'h0F, 2'd2};
        vecs[9]  = '{1'b0, 4'b1111, D,             1'b1, 4'b1000, 1'b1, 8'h00, 2'd3};
        vecs[10] = '{1'b0, 4'b1111, D,             1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0};
        vecs[11] = '{1'b0, 4'b1111, D,             1'b0, 4'b0000, 1'b1, 8'hC0, 2'd0};
        vecs[12] = '{1'b0, 4'b1111, D,             1'b0, 4'b0000, 1'b1, 8'hC0, 2'd0};
        vecs[13] = '{1'b0, 4'b1111, D,             1'b0, 4'b0000, 1'b1, 8'hC0, 2'd0};
        vecs[14] = '{1'b0, 4'b1111, D,             1'b1, 4'b0010, 1'b1, 8'h80, 2'd1};
        vecs[15] = '{1'b0, 4'b1111, D,             1'b0, 4'b0000, 1'b1, 8'h80, 2'd1};
        vecs[16] = '{1'b1, 4'b1111, D,             1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[17] = '{1'b0, 4'b1111, D,             1'b0, 4'b0001, 1'b1, 8'hC0, 2'd0};
        vecs[18] = '{1'b0, 4'b0001, D,             1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0};
        vecs[19] = '{1'b0, 4'b1001, D,             1'b1, 4'b1000, 1'b1, 8'h00, 2'd3};
        vecs[20] = '{1'b0, 4'b0110, D,             1'b0, 4'b0000, 1'b1, 8'h00, 2'd3};
        vecs[21] = '{1'b0, 4'b0110, D,             1'b1, 4'b0010, 1'b1, 8'h80, 2'd1};

        for (int i = 0; i < 22; i++) begin
            step(i, vecs[i]);
        end

        // Fairness: after reset, all valid and draining -> src cycles 0..3.
        step(100, '{1'b1, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        for (int c = 0; c < 8; c++) begin
            vec_t v;
            logic [7:0] g;
            case (c % 4)
                0: g = 8'hC0;
                1: g = 8'h80;
                2: g = 8'h0F;
                default: g = 8'h00;
            endcase
            v = '{1'b0, 4'b1111, D, 1'b1, 4'(1 << (c % 4)), 1'b1, g, 2'(c % 4)};
            step(200 + c, v);
        end

        // Non-granted data changing during a stall must not disturb the held slot.
        for (int c = 0; c < 3; c++) begin
            step(300 + c, '{1'b0, 4'b1111, 32'($urandom), 1'b0,
                            4'b0000, 1'b1, 8'h00, 2'd3});
        end

`ifdef GRAY_ENC_ARBITER_PARITY_EN
        step(400, '{1'b1, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        check("out_par_rst", 400, 32'(out_par), 32'd0);
        step(401, '{1'b0, 4'b0001, 32'h0000_0007, 1'b1, 4'b0001, 1'b1, 8'h04, 2'd0});
        check("out_par", 401, 32'(out_par), 32'd1);
        step(402, '{1'b0, 4'b0010, 32'h0000_0F00, 1'b1, 4'b0010, 1'b1, 8'h08, 2'd1});
        check("out_par", 402, 32'(out_par), 32'd0);
        step(403, '{1'b0, 4'b0100, 32'h0007_0000, 1'b0, 4'b0000, 1'b1, 8'h08, 2'd1});
        check("out_par_hold", 403, 32'(out_par), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_enc_arbiter.md
Name: gray_enc_arbiter

Overview:
- Round-robin arbiter that shares one binary-to-Gray conversion stage among NREQ requesters.
- Each requester presents a W-bit binary word with a valid/ready handshake.
- The block grants one requester per cycle, converts the word (gray = bin ^ (bin >> 1)), and holds the result in a single registered output slot tagged with the source index.
- Sits between producer channels and a shared downstream Gray-code consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, data width in bits.
- SW, $clog2(NREQ), width of the source-index field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*W  packed binary words; requester i occupies bits [i*W +: W].
- req_ready  output  NREQ  one-hot grant/accept; combinational.
- out_valid  output  1  output slot holds a result.
- out_gray  output  W  Gray-coded result.
- out_src  output  SW  index of the requester that produced out_gray.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: clears the slot.
  - rst=1 at an edge forces out_valid=0, out_gray=0, out_src=0, rr_ptr=0, state=EMPTY.
  - req_ready=0 in any cycle where rst=1.
- State machine (slot occupancy):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: can_take = (state==EMPTY) | (out_ready & out_valid).
  - A zero-bubble pass-through is allowed when full and draining in the same cycle.
- Arbitration:
  - Among asserted req_valid, grant the first index at or after rr_ptr, searching upward with wrap-around modulo NREQ.
  - req_ready[g]=1 only when can_take=1 and a grant exists; all other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and out_ready. No valid/ready combinational loop: req_valid must not depend on req_ready.
- Transfer on requester g (req_valid[g] & req_ready[g]):
  - Next edge: out_gray <= gray(req_data[g]), out_src <= g, out_valid <= 1, state <= FULL.
  - rr_ptr <= (g+1) mod NREQ.
  - Latency is exactly 1 cycle from accept to out_valid.
- Drain without new accept (out_valid & out_ready & no grant):
  - Next edge: out_valid <= 0, state <= EMPTY. out_gray/out_src keep their last values.
- Stall: out_valid & !out_ready.
  - out_gray and out_src hold stable.
  - All req_ready=0.
  - rr_ptr unchanged.
- No requests: rr_ptr unchanged; state follows the drain rule.
- Fairness: with all NREQ requesters continuously valid and out_ready=1, grants cycle 0,1,..,NREQ-1,0 with one grant per cycle.
- Gray arithmetic:
  - gray[W-1] = bin[W-1].
  - gray[k] = bin[k+1] ^ bin[k] for k < W-1.
  - Purely bitwise; no carries.
- Reset mid-operation:
  - A held result is discarded.
  - A handshake coinciding with rst=1 is not accepted (req_ready forced 0).
- req_data of non-granted requesters is ignored.

Optional Feature:
- Macro: GRAY_ENC_ARBITER_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit), registered alongside out_gray.
  - out_par = XOR-reduce of the accepted binary word. It is computed from the binary input, not the Gray output.
  - Reset value is 0; it holds stable during a stall.
- Undefined:
  - Port out_par and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_gray=0x00, out_src=0, req_ready=0000. After release with no req_valid -> state stays EMPTY.
- Single requester: req_valid=0010, req_data[1]=0x55, out_ready=1 -> req_ready=0010. Next cycle out_valid=1, out_gray=0x7F, out_src=1. rr_ptr=2.
- Round-robin: all four valid with data 0x80, 0xFF, 0x0A, 0x00 and out_ready=1 -> on consecutive cycles out_src=0,1,2,3,0 and out_gray=0xC0, 0x80, 0x0F, 0x00, 0xC0.
- Backpressure: slot FULL with 0xC0/src 0, out_ready=0 for 3 cycles, req_valid=1111 -> req_ready=0000, outputs stable. out_ready=1 -> same-cycle grant to req 1, and the next cycle shows out_src=1 with no bubble.
- Reset mid-stall: slot FULL, out_ready=0, assert rst one cycle -> out_valid=0 and rr_ptr=0. The next grant goes to requester 0 if valid.
- Parity (GRAY_ENC_ARBITER_PARITY_EN defined): input 0x07 -> out_gray=0x04, out_par=1. Input 0x0F -> out_gray=0x08, out_par=0.
